// File: rtl/exu_wb_arbiter.sv
// exu_wb_arbiter: round-robin merge of NSRC execution-unit writeback channels into one
// registered ROB writeback port. Optional perf counters are enabled by WB_ARB_PERF_CNT_EN.
module exu_wb_arbiter #(
    parameter int NSRC   = 3,
    parameter int XLEN   = 64,
    parameter int ITAG_W = 8,
    localparam int SW    = $clog2(NSRC)
) (
    input  logic                   clk_i,
    input  logic                   arst_ni,
    input  logic                   flush_i,
    input  logic [NSRC-1:0]        src_valid_i,
    output logic [NSRC-1:0]        src_ready_o,
    input  logic [NSRC*XLEN-1:0]   src_data_i,
    input  logic [NSRC*XLEN-1:0]   src_baddr_i,
    input  logic [NSRC-1:0]        src_jump_i,
    input  logic [NSRC*ITAG_W-1:0] src_itag_i,
    output logic                   wb_valid_o,
    input  logic                   wb_ready_i,
    output logic [XLEN-1:0]        wb_data_o,
    output logic [XLEN-1:0]        wb_baddr_o,
    output logic                   wb_jump_o,
    output logic [ITAG_W-1:0]      wb_itag_o,
    output logic [SW-1:0]          wb_src_o
`ifdef WB_ARB_PERF_CNT_EN
    ,
    output logic [31:0]            perf_conflict_o,
    output logic [31:0]            perf_stall_o
`endif
);

    logic              wb_valid_q, wb_valid_d;
    logic [SW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [XLEN-1:0]   wb_data_q, wb_baddr_q;
    logic              wb_jump_q;
    logic [ITAG_W-1:0] wb_itag_q;
    logic [SW-1:0]     wb_src_q;

    logic [NSRC-1:0]   grant;
    logic [SW-1:0]     grant_idx;
    logic              grant_any;
    logic              load_en;
    logic              xfer;

    // Scan starts one past the last winner so every requester is reached within NSRC grants.
    always_comb begin
        int idx;
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        idx       = 0;
        grant     = '0;
        grant_idx = rr_ptr_q;
        grant_any = 1'b0;
        for (int k = 1; k <= NSRC; k++) begin
            idx = (int'(rr_ptr_q) + k) % NSRC;
            if (!grant_any && src_valid_i[idx]) begin
                grant_any  = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = SW'(idx);
            end
        end
    end

    assign load_en     = !(wb_valid_q && !wb_ready_i);
    assign src_ready_o = grant & {NSRC{load_en && !flush_i}};
    assign xfer        = grant_any && load_en && !flush_i;

    always_comb begin
        wb_valid_d = wb_valid_q;
        rr_ptr_d   = rr_ptr_q;
        if (flush_i) begin
            wb_valid_d = 1'b0;
        end else if (load_en) begin
            wb_valid_d = grant_any;
            if (grant_any) begin
                rr_ptr_d = grant_idx;
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            wb_valid_q <= 1'b0;
            rr_ptr_q   <= SW'(NSRC - 1);
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            wb_valid_q <= wb_valid_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    // NOTE: the payload is qualified by wb_valid_q, so it carries no reset and stays a plain enable flop.
    always_ff @(posedge clk_i) begin
        if (xfer) begin
            wb_data_q  <= src_data_i[grant_idx*XLEN +: XLEN];
            wb_baddr_q <= src_baddr_i[grant_idx*XLEN +: XLEN];
            wb_jump_q  <= src_jump_i[grant_idx];
            wb_itag_q  <= src_itag_i[grant_idx*ITAG_W +: ITAG_W];
            wb_src_q   <= grant_idx;
        end
    end

    assign wb_valid_o = wb_valid_q;
    assign wb_data_o  = wb_data_q;
    assign wb_baddr_o = wb_baddr_q;
    assign wb_jump_o  = wb_jump_q;
    assign wb_itag_o  = wb_itag_q;
    assign wb_src_o   = wb_src_q;

`ifdef WB_ARB_PERF_CNT_EN
    logic [31:0] perf_conflict_q, perf_conflict_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    // A conflict is a cycle where the output could load and at least one requester lost.
    always_comb begin
        perf_conflict_d = perf_conflict_q;
        perf_stall_d    = perf_stall_q;
        if (($countones(src_valid_i) >= 2) && load_en) begin
            perf_conflict_d = perf_conflict_q + 32'd1;
        end
        if (wb_valid_q && !wb_ready_i) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            perf_conflict_q <= '0;
            perf_stall_q    <= '0;
        end else begin
            perf_conflict_q <= perf_conflict_d;
            perf_stall_q    <= perf_stall_d;
        end
    end

    assign perf_conflict_o = perf_conflict_q;
    assign perf_stall_o    = perf_stall_q;
`endif

endmodule

// File: tb/tb_exu_wb_arbiter.sv
// Self-checking bench for exu_wb_arbiter: directed scenarios with literal expectations plus
// a randomized phase compared every cycle against a behavioural round-robin model.
module tb_exu_wb_arbiter;

    localparam int NSRC   = 3;
    localparam int XLEN   = 64;
    localparam int ITAG_W = 8;
    localparam int SW     = $clog2(NSRC);

    logic                   clk_i;
    logic                   arst_ni;
    logic                   flush_i;
    logic [NSRC-1:0]        src_valid_i;
    logic [NSRC-1:0]        src_ready_o;
    logic [NSRC*XLEN-1:0]   src_data_i;
    logic [NSRC*XLEN-1:0]   src_baddr_i;
    logic [NSRC-1:0]        src_jump_i;
    logic [NSRC*ITAG_W-1:0] src_itag_i;
    logic                   wb_valid_o;
    logic                   wb_ready_i;
    logic [XLEN-1:0]        wb_data_o;
    logic [XLEN-1:0]        wb_baddr_o;
    logic                   wb_jump_o;
    logic [ITAG_W-1:0]      wb_itag_o;
    logic [SW-1:0]          wb_src_o;
`ifdef WB_ARB_PERF_CNT_EN
    logic [31:0]            perf_conflict_o;
    logic [31:0]            perf_stall_o;
`endif

    int n_checks = 0;
    int n_errors = 0;

    exu_wb_arbiter #(.NSRC(NSRC), .XLEN(XLEN), .ITAG_W(ITAG_W)) dut (
        .clk_i       (clk_i),
        .arst_ni     (arst_ni),
        .flush_i     (flush_i),
        .src_valid_i (src_valid_i),
        .src_ready_o (src_ready_o),
        .src_data_i  (src_data_i),
        .src_baddr_i (src_baddr_i),
        .src_jump_i  (src_jump_i),
        .src_itag_i  (src_itag_i),
        .wb_valid_o  (wb_valid_o),
        .wb_ready_i  (wb_ready_i),
        .wb_data_o   (wb_data_o),
        .wb_baddr_o  (wb_baddr_o),
        .wb_jump_o   (wb_jump_o),
        .wb_itag_o   (wb_itag_o),
        .wb_src_o    (wb_src_o)
`ifdef WB_ARB_PERF_CNT_EN
        ,
        .perf_conflict_o (perf_conflict_o),
        .perf_stall_o    (perf_stall_o)
`endif
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the output register is an entry that is either empty or holds the
    // payload of the last accepted source; the winner is the valid source nearest after rr.
    logic              m_valid;
    int                m_rr;
    logic [XLEN-1:0]   m_data, m_baddr;
    logic              m_jump;
    logic [ITAG_W-1:0] m_itag;
    int                m_src;

    always begin
        int              w, best_d, d;
        logic            can_load;
        logic [NSRC-1:0] exp_ready;
        @(negedge clk_i);
        if (!arst_ni) begin
            m_valid = 1'b0;
            m_rr    = NSRC - 1;
            check("rst_valid", 64'(wb_valid_o), 64'd0);
        end else begin
            w      = -1;
            best_d = NSRC;
            for (int i = 0; i < NSRC; i++) begin
                d = (i - m_rr - 1 + 2 * NSRC) % NSRC;
                if (src_valid_i[i] && d < best_d) begin
                    best_d = d;
                    w      = i;
                end
            end
            can_load  = !(m_valid && !wb_ready_i);
            exp_ready = '0;
            if (w >= 0 && can_load && !flush_i) exp_ready[w] = 1'b1;
            check("m_ready", 64'(src_ready_o), 64'(exp_ready));
            check("m_valid", 64'(wb_valid_o), 64'(m_valid));
            if (m_valid) begin
                check("m_data",  wb_data_o,         m_data);
                check("m_baddr", wb_baddr_o,        m_baddr);
                check("m_jump",  64'(wb_jump_o),    64'(m_jump));
                check("m_itag",  64'(wb_itag_o),    64'(m_itag));
                check("m_src",   64'(wb_src_o),     64'(m_src));
            end
            if (flush_i) begin
                m_valid = 1'b0;
            end else if (can_load) begin
                if (w >= 0) begin
                    m_valid = 1'b1;
                    m_rr    = w;
                    m_src   = w;
                    m_data  = src_data_i[w*XLEN +: XLEN];
                    m_baddr = src_baddr_i[w*XLEN +: XLEN];
                    m_jump  = src_jump_i[w];
                    m_itag  = src_itag_i[w*ITAG_W +: ITAG_W];
                end else begin
                    m_valid = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_src(input int i, input logic [XLEN-1:0] data, input logic [ITAG_W-1:0] itag);
        src_data_i[i*XLEN +: XLEN]     = data;
        src_baddr_i[i*XLEN +: XLEN]    = ~data;
        src_itag_i[i*ITAG_W +: ITAG_W] = itag;
        src_jump_i[i]                  = data[0];
    endtask

    task automatic reset_pulse();
        arst_ni = 1'b0;
        tick();
        arst_ni = 1'b1;
    endtask

    initial begin
        arst_ni     = 1'b0;
        flush_i     = 1'b0;
        src_valid_i = '0;
        src_data_i  = '0;
        src_baddr_i = '0;
        src_jump_i  = '0;
        src_itag_i  = '0;
        wb_ready_i  = 1'b0;
        tick();
        tick();
        check("reset_valid", 64'(wb_valid_o), 64'd0);
        arst_ni = 1'b1;

        // Single source: src1 alone
        set_src(1, 64'h1234, 8'd5);
        src_valid_i = 3'b010;
        wb_ready_i  = 1'b1;
        tick();
        check("t1_valid", 64'(wb_valid_o), 64'd1);
        check("t1_data",  wb_data_o,       64'h1234);
        check("t1_itag",  64'(wb_itag_o),  64'd5);
        check("t1_src",   64'(wb_src_o),   64'd1);
        src_valid_i = '0;
        tick();
        check("t1_drain", 64'(wb_valid_o), 64'd0);

        // All sources continuously valid after reset: 0,1,2,0,1,2 with no bubbles
        reset_pulse();
        for (int i = 0; i < NSRC; i++) set_src(i, 64'h1111 * (i + 1), 8'(i + 10));
        src_valid_i = 3'b111;
        wb_ready_i  = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("t2_valid", 64'(wb_valid_o), 64'd1);
            check("t2_src",   64'(wb_src_o),   64'(k % 3));
            check("t2_data",  wb_data_o,       64'h1111 * ((k % 3) + 1));
        end

        // ROB stall with src2 pending: outputs hold, no ready, then src2 entry appears
        src_valid_i = 3'b100;
        set_src(2, 64'hBEEF, 8'd77);
        wb_ready_i  = 1'b0;
        #1;
        check("t3_ready_stall", 64'(src_ready_o), 64'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t3_hold_valid", 64'(wb_valid_o),  64'd1);
            check("t3_hold_src",   64'(wb_src_o),    64'd2);
            check("t3_hold_data",  wb_data_o,        64'h3333);
            check("t3_hold_ready", 64'(src_ready_o), 64'd0);
        end
        wb_ready_i = 1'b1;
        tick();
        check("t3_new_data", wb_data_o,      64'hBEEF);
        check("t3_new_itag", 64'(wb_itag_o), 64'd77);

        // Flush with output valid and src0 valid
        set_src(0, 64'hF00D, 8'd3);
        src_valid_i = 3'b001;
        flush_i     = 1'b1;
        #1;
        check("t4_ready_flush", 64'(src_ready_o), 64'd0);
        tick();
        check("t4_valid_flush", 64'(wb_valid_o), 64'd0);
        flush_i     = 1'b0;
        src_valid_i = '0;
        tick();
        check("t4_no_capture", 64'(wb_valid_o), 64'd0);

        // Async reset during a ROB stall
        src_valid_i = 3'b010;
        tick();
        check("t5_valid", 64'(wb_valid_o), 64'd1);
        src_valid_i = '0;
        wb_ready_i  = 1'b0;
        tick();
        check("t5_stalled", 64'(wb_valid_o), 64'd1);
        arst_ni = 1'b0;
        #1;
        check("t5_async_clear", 64'(wb_valid_o), 64'd0);
        tick();
        arst_ni     = 1'b1;
        src_valid_i = 3'b111;
        wb_ready_i  = 1'b1;
        tick();
        check("t5_first_src0", 64'(wb_src_o), 64'd0);
        src_valid_i = '0;
        tick();

`ifdef WB_ARB_PERF_CNT_EN
        // Two sources valid for 10 cycles with ROB always ready
        reset_pulse();
        src_valid_i = 3'b011;
        wb_ready_i  = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        src_valid_i = '0;
        check("t6_conflict", 64'(perf_conflict_o), 64'd10);
        check("t6_stall",    64'(perf_stall_o),    64'd0);
        tick();
`endif

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            tick();
            arst_ni     = ($urandom_range(0, 299) != 0);
            flush_i     = ($urandom_range(0, 19) == 0);
            wb_ready_i  = ($urandom_range(0, 9) < 7);
            src_valid_i = NSRC'($urandom);
            for (int i = 0; i < NSRC; i++) set_src(i, {$urandom, $urandom}, ITAG_W'($urandom));
        end
        tick();
        arst_ni = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
